// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a PC through an asynchronous ROM and hands
// one registered instruction at a time to decode, with stall, redirect and halt.
module instr_fetch_ctrl #(
   parameter int          TAM_POSICIONES = 1024,
   parameter int          TAM_PALABRA    = 32,
   parameter logic [31:0] RESET_PC       = 32'd0
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic                              start_i,
   input  logic                              halt_i,
   input  logic                              branch_taken_i,
   input  logic [31:0]                       branch_target_i,
   output logic [$clog2(TAM_POSICIONES)-1:0] rom_addr_o,
   output logic                              rom_read_en_o,
   input  logic [TAM_PALABRA-1:0]            rom_data_i,
   output logic [TAM_PALABRA-1:0]            instr_o,
   output logic [31:0]                       instr_pc_o,
   output logic                              instr_valid_o,
   input  logic                              instr_ready_i,
   output logic                              busy_o,
   output logic                              addr_error_o,
   output logic [1:0]                        state_o
);

   localparam int AW = $clog2(TAM_POSICIONES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [TAM_PALABRA-1:0] instr_q, instr_d;
   logic [31:0]            instr_pc_q, instr_pc_d;
   logic                   instr_valid_q, instr_valid_d;
   logic                   addr_error_q, addr_error_d;

   logic                   target_ok;
   logic                   pc_last;
   logic [31:0]            pc_inc;

   // Handshake: instr_o/instr_pc_o transfer to decode on any rising edge where
   // instr_valid_o and instr_ready_i are both high; valid never drops on a stall.
   assign target_ok = (branch_target_i[1:0] == 2'b00) &&
                      ({2'b00, branch_target_i[31:2]} < 32'(TAM_POSICIONES));

   // The word index wraps modulo the ROM size, also for non power-of-two sizes.
   assign pc_last = ({2'b00, pc_q[31:2]} >= 32'(TAM_POSICIONES - 1));
   assign pc_inc  = pc_last ? 32'd0 : pc_q + 32'd4;

   assign rom_addr_o    = pc_q[AW+1:2];
   assign rom_read_en_o = (state_q == ST_FETCH) && !branch_taken_i && !halt_i;
   assign busy_o        = (state_q == ST_FETCH);
   assign instr_o       = instr_q;
   assign instr_pc_o    = instr_pc_q;
   assign instr_valid_o = instr_valid_q;
   assign addr_error_o  = addr_error_q;
   assign state_o       = state_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      addr_error_d  = addr_error_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i && !halt_i) begin
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            if (halt_i) begin
               state_d       = ST_IDLE;
               instr_valid_d = 1'b0;
            end else if (branch_taken_i) begin
               instr_valid_d = 1'b0;
               if (target_ok) begin
                  pc_d = branch_target_i;
               end else begin
                  addr_error_d = 1'b1;
                  state_d      = ST_ERROR;
               end
            end else if (!instr_valid_q || instr_ready_i) begin
               instr_d       = rom_data_i;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_inc;
            end
         end

         ST_ERROR: begin
            state_d = ST_ERROR;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         addr_error_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         addr_error_q  <= addr_error_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios then random traffic, checked
// against a word-level reference model through expected-value queues.
module tb_instr_fetch_ctrl;

   localparam int TAM = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, halt, br_taken, ready;
   logic [31:0] br_target;
   logic [9:0]  rom_addr;
   logic        rom_rd_en;
   logic [31:0] rom_data;
   logic [31:0] instr, instr_pc;
   logic        instr_valid, busy, addr_error;
   logic [1:0]  state_dbg;

   logic [31:0] rom [TAM];

   instr_fetch_ctrl #(.TAM_POSICIONES(TAM), .TAM_PALABRA(32), .RESET_PC(32'd0)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .halt_i(halt),
      .branch_taken_i(br_taken), .branch_target_i(br_target),
      .rom_addr_o(rom_addr), .rom_read_en_o(rom_rd_en), .rom_data_i(rom_data),
      .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(instr_valid),
      .instr_ready_i(ready), .busy_o(busy), .addr_error_o(addr_error),
      .state_o(state_dbg)
   );

   always #5 clk = ~clk;
   assign rom_data = rom[rom_addr];

   // ---------------- reference model (word indices, modes) ----------------
   localparam int M_IDLE = 0, M_RUN = 1, M_ERR = 2;
   int          m_mode;
   int unsigned m_word;
   logic        m_valid, m_err;
   logic [31:0] m_instr, m_ipc;

   // status: busy, err, rd_en, valid, rom_addr[9:0], instr, instr_pc
   logic [77:0] st_q[$];
   logic [63:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   function automatic logic [31:0] rom_word(input int unsigned w);
      return 32'h1000 + w;
   endfunction

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_word  = 0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_instr = 32'd0;
      m_ipc   = 32'd0;
   endtask

   task automatic model_step(input logic r, s, h, b, input logic [31:0] t, input logic rd);
      logic busy_e, rd_e;
      logic [9:0] addr_e;
      busy_e = (m_mode == M_RUN);
      rd_e   = busy_e && !b && !h;
      addr_e = 10'(m_word % TAM);
      st_q.push_back({busy_e, m_err, rd_e, m_valid, addr_e, m_instr, m_ipc});
      if (m_valid && rd) exp_q.push_back({m_ipc, m_instr});
      if (!r) begin
         model_reset();
      end else if (m_mode == M_IDLE) begin
         if (s && !h) m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         if (h) begin
            m_mode  = M_IDLE;
            m_valid = 1'b0;
         end else if (b) begin
            m_valid = 1'b0;
            if ((t % 4 == 0) && (t / 4 < TAM)) begin
               m_word = t / 4;
            end else begin
               m_err  = 1'b1;
               m_mode = M_ERR;
            end
         end else if (!m_valid || rd) begin
            m_instr = rom_word(m_word);
            m_ipc   = 4 * m_word;
            m_valid = 1'b1;
            m_word  = (m_word + 1) % TAM;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic drive(input logic r, s, h, b, input logic [31:0] t, input logic rd);
      @(posedge clk);
      #2;
      rst_n     = r;
      start     = s;
      halt      = h;
      br_taken  = b;
      br_target = t;
      ready     = rd;
      model_step(r, s, h, b, t, rd);
   endtask

   task automatic run(input int n, input logic s, input logic rd);
      for (int i = 0; i < n; i++) drive(1'b1, s, 1'b0, 1'b0, 32'd0, rd);
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [77:0] st_e, st_a;
      logic [63:0] x_e;
      if (st_q.size() > 0) begin
         st_e = st_q.pop_front();
         st_a = {busy, addr_error, rom_rd_en, instr_valid, rom_addr, instr, instr_pc};
         n_checks++;
         if (st_a === st_e) n_pass++;
         else $display("FAIL status @%0t: got %h expected %h", $time, st_a, st_e);
         if (instr_valid === 1'b1 && ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL handoff @%0t: got pc=%h instr=%h, expected none", $time, instr_pc, instr);
            end else begin
               x_e = exp_q.pop_front();
               if ({instr_pc, instr} === x_e) n_pass++;
               else $display("FAIL handoff @%0t: got pc=%h instr=%h expected pc=%h instr=%h",
                             $time, instr_pc, instr, x_e[63:32], x_e[31:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] tgt;
      int unsigned k;
      for (int i = 0; i < TAM; i++) rom[i] = 32'h1000 + i;
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; br_taken = 1'b0; ready = 1'b0;
      br_target = 32'd0;
      repeat (2) @(posedge clk);
      model_reset();
      do_reset();

      // idle after reset: no reads without start
      run(3, 1'b0, 1'b1);
      // streaming 0x1000,0x1001,0x1002
      run(5, 1'b1, 1'b1);

      // stall for three cycles after the first instruction
      do_reset();
      run(2, 1'b1, 1'b1);
      run(3, 1'b1, 1'b0);
      run(3, 1'b1, 1'b1);

      // redirect to 0x40 while INSTR_PC=8
      do_reset();
      run(4, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
      run(3, 1'b1, 1'b1);

      // misaligned target, START ignored in error, then out-of-range target
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h42, 1'b1);
      run(3, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1);
      do_reset();
      run(3, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'(4 * TAM), 1'b1);
      run(2, 1'b1, 1'b0);
      do_reset();

      // wrap from the last word, halt beats branch, reset mid-stall
      run(2, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFC, 1'b1);
      run(4, 1'b1, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
      run(2, 1'b0, 1'b1);
      run(3, 1'b1, 1'b0);
      do_reset();
      run(2, 1'b0, 1'b0);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         k = $urandom_range(0, 7);
         if (k == 0)      tgt = {20'd0, 10'($urandom_range(0, TAM - 1)), 2'($urandom_range(1, 3))};
         else if (k == 1) tgt = 32'(4 * $urandom_range(TAM, 4 * TAM));
         else             tgt = 32'(4 * $urandom_range(0, TAM - 1));
         drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
               tgt, ($urandom_range(0, 3) != 0));
      end
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;

      n_checks++;
      if (exp_q.size() == 0 && st_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d handoffs and %0d status entries left, expected 0 and 0",
                    exp_q.size(), st_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameters SHALL be: TAM_POSICIONES, default 1024, number of ROM words; TAM_PALABRA, default 32, instruction width; RESET_PC, default 0, byte address loaded at reset.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  in  1  reset, synchronous, active-low.
REQ-004 START  in  1  level; starts fetching from the current PC when in IDLE.
REQ-005 HALT  in  1  level; stops fetching and returns to IDLE.
REQ-006 BRANCH_TAKEN  in  1  one-cycle redirect request.
REQ-007 BRANCH_TARGET  in  32  byte address of the redirect.
REQ-008 ROM_ADDR  out  $clog2(TAM_POSICIONES)  word address driven to the asynchronous ROM.
REQ-009 ROM_READ_EN  out  1  ROM read enable.
REQ-010 ROM_DATA  in  TAM_PALABRA  combinational ROM read data.
REQ-011 INSTR  out  TAM_PALABRA  registered instruction to decode.
REQ-012 INSTR_PC  out  32  byte address of INSTR.
REQ-013 INSTR_VALID  out  1  INSTR/INSTR_PC hold a valid instruction.
REQ-014 INSTR_READY  in  1  decode accepts INSTR this cycle.
REQ-015 BUSY  out  1  high in FETCH.
REQ-016 ADDR_ERROR  out  1  sticky misaligned/out-of-range branch target flag.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, ERROR; internal registers are PC (32 b), INSTR, INSTR_PC, INSTR_VALID.
REQ-018 ROM_ADDR SHALL equal PC[$clog2(TAM_POSICIONES)+1:2] combinationally in all states.
REQ-019 ROM_READ_EN SHALL be 1 only in FETCH with no BRANCH_TAKEN and no HALT asserted, and 0 otherwise.
REQ-020 A capture SHALL occur in FETCH when ROM_READ_EN=1 and (INSTR_VALID=0 or INSTR_READY=1): INSTR<=ROM_DATA, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+4.
REQ-021 Latency SHALL be 1 cycle: the word at PC appears on INSTR the cycle after its capture edge; with INSTR_READY held at 1 throughput is one instruction per cycle.
REQ-022 INSTR_VALID=1 and INSTR_READY=0 SHALL hold INSTR, INSTR_PC, PC and INSTR_VALID unchanged (stall).
REQ-023 INSTR_VALID=1 and INSTR_READY=1 with no capture SHALL clear INSTR_VALID.
REQ-024 PC+4 past word TAM_POSICIONES-1 SHALL wrap PC to 0 (word index modulo TAM_POSICIONES); no error is raised.
REQ-025 Valid transitions: IDLE->FETCH when START=1 and HALT=0; FETCH->IDLE when HALT=1; FETCH->ERROR on an invalid branch; ERROR is left only by reset.
REQ-026 In FETCH, a BRANCH_TAKEN with a valid target SHALL set PC<=BRANCH_TARGET and INSTR_VALID<=0 (flush), with no capture that cycle; the target word is captured the following cycle.
REQ-027 A target SHALL be valid iff BRANCH_TARGET[1:0]=0 and BRANCH_TARGET[31:2] < TAM_POSICIONES.
REQ-028 An invalid BRANCH_TARGET in FETCH SHALL set ADDR_ERROR<=1, INSTR_VALID<=0, PC unchanged, and enter ERROR.
REQ-029 BRANCH_TAKEN in IDLE or ERROR SHALL be ignored.
REQ-030 HALT=1 in FETCH SHALL: enter IDLE, clear INSTR_VALID, keep PC; HALT has priority over BRANCH_TAKEN.
REQ-031 An instruction accepted (INSTR_READY=1) in the same cycle as a flush or HALT counts as consumed.
REQ-032 BUSY=1 iff state is FETCH.

Reset
REQ-033 RST_N=0 at a rising edge SHALL set: state IDLE, PC=RESET_PC, INSTR=0, INSTR_PC=0, INSTR_VALID=0, ADDR_ERROR=0, BUSY=0.
REQ-034 Reset SHALL take priority over all inputs in any state, including mid-stall and ERROR.
REQ-035 After reset release, ROM_READ_EN SHALL stay 0 until START is sampled high.

Verification
REQ-036 ROM words w[i]=0x1000+i, START=1, INSTR_READY=1 -> INSTR 0x1000,0x1001,0x1002 on consecutive cycles, INSTR_PC 0,4,8.
REQ-037 INSTR_READY=0 for 3 cycles after the first instruction -> INSTR=0x1000 and INSTR_PC=0 held, ROM_ADDR held at 1; on READY=1 -> 0x1001 next.
REQ-038 BRANCH_TAKEN with target 0x40 while INSTR_PC=8 -> INSTR_VALID=0 for one cycle, then INSTR=w[16], INSTR_PC=0x40.
REQ-039 Target 0x42, then separately target 4*TAM_POSICIONES -> ADDR_ERROR=1, state ERROR, ROM_READ_EN=0, START ignored until RST_N=0.
REQ-040 PC at word 1023, READY=1 -> INSTR_PC=0xFFC followed by INSTR_PC=0; HALT+BRANCH same cycle -> IDLE, PC unchanged; RST_N=0 mid-stall -> all outputs per REQ-033 next cycle.
